// File: rtl/spi_module_slave.sv
// SPI slave with CPOL/CPHA modes: SCLK, CS and MOSI are 2-FF synchronized into clk, 8-bit MSB-first frames.
// A one-deep TX holding register feeds each byte; back-to-back bytes continue under one chip select.
module spi_module_slave #(
  parameter logic CPOL = 1'b0,
  parameter logic CPHA = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] spi_miso_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] spi_mosi_data,
  output logic       payload_done,
  output logic       tx_underrun
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_cs_s1, r_cs_s2, r_cs_s3;
  logic r_mosi_s1, r_mosi_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_s1 <= CPOL;
      r_sclk_s2 <= CPOL;
      r_sclk_s3 <= CPOL;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_s3   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= spi_clk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= spi_cs;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic       r_miso;
  logic       r_miso_oe;
  logic [7:0] r_hold;
  logic       r_hold_vld;
  logic [7:0] r_mosi_data;
  logic       r_payload_done;
  logic       r_underrun;
  logic       r_byte_end;

  logic       w_sclk_edge, w_lead, w_trail, w_cs_fall;
  logic       w_in_byte, w_byte_start, w_sample, w_shift, w_accept;
  logic [7:0] w_load;

  assign w_sclk_edge  = r_sclk_s2 ^ r_sclk_s3;
  assign w_lead       = w_sclk_edge && (r_sclk_s3 == CPOL);
  assign w_trail      = w_sclk_edge && (r_sclk_s2 == CPOL);
  assign w_cs_fall    = r_cs_s3 && !r_cs_s2;
  assign w_in_byte    = (r_state == ST_ACTIVE) && !r_cs_s2;
  assign w_byte_start = ((r_state == ST_IDLE) && w_cs_fall) || (w_in_byte && r_byte_end);
  assign w_sample     = w_in_byte && (CPHA ? w_trail : w_lead);
  // In mode CPHA=0 the MSB is already on the line at byte start, so the trailing
  // edge that closes the previous byte (counter back at 0) must not shift.
  assign w_shift      = w_in_byte && (CPHA ? w_lead : (w_trail && (r_bit_cnt != 3'd0)));
  assign w_load       = r_hold_vld ? r_hold : 8'h00;
  assign w_accept     = tx_valid && !r_hold_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_bit_cnt      <= 3'd0;
      r_rx_shift     <= 7'd0;
      r_tx_shift     <= 8'h00;
      r_miso         <= 1'b0;
      r_miso_oe      <= 1'b0;
      r_hold         <= 8'h00;
      r_hold_vld     <= 1'b0;
      r_mosi_data    <= 8'h00;
      r_payload_done <= 1'b0;
      r_underrun     <= 1'b0;
      r_byte_end     <= 1'b0;
    end else begin
      r_payload_done <= 1'b0;
      r_underrun     <= 1'b0;
      r_byte_end     <= 1'b0;
      r_miso_oe      <= !r_cs_s2;
      // A byte arriving in the byte-start cycle is kept for the following byte.
      r_hold_vld     <= (r_hold_vld && !w_byte_start) || w_accept;
      if (w_accept) begin
        r_hold <= spi_miso_data;
      end
      if (w_byte_start) begin
        r_underrun <= !r_hold_vld;
      end

      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= 3'd0;
          r_miso    <= 1'b0;
          if (w_cs_fall) begin
            r_state    <= ST_ACTIVE;
            r_tx_shift <= w_load;
            r_miso     <= CPHA ? 1'b0 : w_load[7];
          end
        end
        ST_ACTIVE: begin
          if (r_cs_s2) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 7'd0;
            r_tx_shift <= 8'h00;
            r_miso     <= 1'b0;
          end else if (w_byte_start) begin
            r_tx_shift <= w_load;
            if (!CPHA) begin
              r_miso <= w_load[7];
            end
          end else begin
            if (w_sample) begin
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              r_rx_shift <= {r_rx_shift[5:0], r_mosi_s2};
              if (r_bit_cnt == 3'd7) begin
                r_mosi_data    <= {r_rx_shift, r_mosi_s2};
                r_payload_done <= 1'b1;
                r_byte_end     <= 1'b1;
              end
            end
            if (w_shift) begin
              r_miso     <= CPHA ? r_tx_shift[7] : r_tx_shift[6];
              r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign spi_miso      = r_miso;
  assign spi_miso_oe   = r_miso_oe;
  assign tx_ready      = !r_hold_vld;
  assign spi_mosi_data = r_mosi_data;
  assign payload_done  = r_payload_done;
  assign tx_underrun   = r_underrun;

endmodule

// File: doc/spi_module_slave.md
SPI_MODULE_SLAVE -- requirements
Module: spi_module_slave

Interface
REQ-001 SHALL have parameter CPOL, default 0, meaning SCLK idle level.
REQ-002 SHALL have parameter CPHA, default 0, meaning 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port spi_clk  input  1  SCLK from master, asynchronous to clk.
REQ-006 SHALL have port spi_cs  input  1  chip select, active-low, asynchronous.
REQ-007 SHALL have port spi_mosi  input  1  serial data from master.
REQ-008 SHALL have port spi_miso  output  1  serial data to master.
REQ-009 SHALL have port spi_miso_oe  output  1  MISO output enable, high while the synchronized CS is active.
REQ-010 SHALL have port spi_miso_data  input  8  next byte to transmit.
REQ-011 SHALL have port tx_valid  input  1  spi_miso_data is valid.
REQ-012 SHALL have port tx_ready  output  1  TX holding register is empty.
REQ-013 SHALL have port spi_mosi_data  output  8  last complete received byte.
REQ-014 SHALL have port payload_done  output  1  one-clk pulse when spi_mosi_data updates.
REQ-015 SHALL have port tx_underrun  output  1  one-clk pulse when a byte starts with an empty holding register.

Function
REQ-016 spi_clk, spi_cs and spi_mosi SHALL each pass through a 2-FF synchronizer. A third register on spi_clk and on spi_cs SHALL provide edge detection.
REQ-017 Leading edge SHALL be the synchronized SCLK transition away from CPOL. Trailing edge SHALL be the transition back to CPOL.
REQ-018 Supported SCLK high time and low time SHALL each be at least 6 clk periods. Behaviour at faster SCLK is undefined.
REQ-019 The FSM SHALL have states IDLE and ACTIVE.
- IDLE -> ACTIVE on synchronized CS falling.
- ACTIVE -> IDLE on synchronized CS rising, or when the synchronized CS is high.
REQ-020 A TX holding register SHALL accept a byte when tx_valid and tx_ready are both high. tx_ready SHALL deassert the next clk.
REQ-021 At byte start, the holding register SHALL move into the TX shift register and tx_ready SHALL reassert the next clk. Byte start is the CS-fall cycle, or the cycle after bit 7 is sampled while CS stays active.
REQ-022 If the holding register is empty at byte start, the shift register SHALL load 8'h00 and tx_underrun SHALL pulse for 1 clk.
REQ-023 Transmission and reception SHALL be MSB first, with an 8-bit frame and a 3-bit bit counter.
REQ-024 CPHA=0: MSB SHALL be on spi_miso at byte start. MOSI SHALL be sampled on the leading edge. MISO SHALL shift on the trailing edge.
REQ-025 CPHA=1: MISO SHALL shift on the leading edge, with the MSB presented at the first leading edge. MOSI SHALL be sampled on the trailing edge.
REQ-026 spi_miso SHALL update within 2 clk of the detected edge.
REQ-027 After the 8th sample, spi_mosi_data SHALL take the assembled byte and payload_done SHALL pulse for exactly 1 clk, both in the cycle after the sample.
REQ-028 After the 8th sample, the bit counter SHALL wrap to 0. Back-to-back bytes under one CS SHALL continue without a gap.
REQ-029 CS rising mid-byte SHALL discard the partial RX byte, with no payload_done. The bit counter SHALL reset to 0, and the FSM SHALL go to IDLE.
REQ-030 On CS rising mid-byte, the unsent TX shift contents SHALL be dropped and the holding register SHALL be kept.
REQ-031 When CS is inactive, spi_miso SHALL be 0 and spi_miso_oe SHALL be 0.
REQ-032 SCLK edges while CS is inactive SHALL be ignored.
REQ-033 When tx_valid rises in the same clk as byte start with the register empty, the new byte SHALL NOT be used for this byte. This byte SHALL send 8'h00 and pulse tx_underrun. The new byte SHALL be stored for the next byte.

Reset
REQ-034 While rst is low, the outputs SHALL be:
- spi_miso = 0, spi_miso_oe = 0, tx_ready = 1.
- spi_mosi_data = 8'h00, payload_done = 0, tx_underrun = 0.
- FSM = IDLE, bit counter = 0.
- Holding register = empty, synchronizers = CPOL for SCLK, 1 for CS, 0 for MOSI.
REQ-035 Reset asserted mid-byte SHALL abort the transfer with no payload_done. After release, the block SHALL wait for a fresh CS fall.

Verification
REQ-036 Mode 0, tx byte preloaded = 8'hA5, master sends 8'h3C -> the master receives 8'hA5, spi_mosi_data = 8'h3C, and payload_done pulses exactly once.
REQ-037 Mode 3 (CPOL=1, CPHA=1), 100 random bytes each preloaded before CS fall -> all 100 bytes correct in both directions and 100 payload_done pulses.
REQ-038 Two bytes under one CS, with 8'h11 preloaded and 8'h22 loaded after tx_ready reasserts, master sends 8'hF0, 8'h0F -> the master gets 8'h11, 8'h22 and the slave gets 8'hF0, 8'h0F.
REQ-039 No tx byte loaded, master sends 8'hFF -> the master receives 8'h00, tx_underrun pulses once, and spi_mosi_data = 8'hFF.
REQ-040 CS deasserted after 4 bits, then a full byte of 8'h5A -> no payload_done for the partial byte. spi_mosi_data = 8'h5A, not corrupted by the partial bits.
REQ-041 rst pulsed low mid-byte -> outputs at the REQ-034 values, and the next full transfer of 8'hC3 is received correctly.
